// File: rtl/usbdev_pkg.sv
// Shared types and constants for the USB device receive path.
//   line_state_t : decoded D+/D- pad state (J, K, SE0, SE1)
//   rx_state_t   : receive framing FSM states
//   line_of()    : maps a raw (dp, dm) pad pair onto line_state_t
package usbdev_pkg;

  typedef enum logic [1:0] {
    J   = 2'd0,
    K   = 2'd1,
    SE0 = 2'd2,
    SE1 = 2'd3
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    EOP   = 3'd3,
    ABORT = 3'd4
  } rx_state_t;

  localparam int USB_STUFF_LIMIT = 6;
  localparam int USB_OVERSAMPLE  = 4;

  function automatic line_state_t line_of(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return J;
      2'b01:   return K;
      2'b00:   return SE0;
      default: return SE1;
    endcase
  endfunction

endpackage

// File: rtl/usbdev_rx_dpll.sv
// Bit clock recovery for the full-speed receiver.
// A phase counter is re-centred on every line-state change and otherwise
// free-runs, so the sample point sits mid-bit even with edge jitter.
//   clk, rst    : core clock, synchronous active-high reset
//   rx_en       : low holds the phase counter cleared and blocks bit_stb
//   dp_i, dm_i  : synchronised pad samples
//   bit_stb     : high for one clock when line_state is the bit sample
//   line_state  : registered line state (valid to sample with bit_stb)
module usbdev_rx_dpll
  import usbdev_pkg::*;
#(
  parameter int OVERSAMPLE = USB_OVERSAMPLE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_en,
  input  logic        dp_i,
  input  logic        dm_i,
  output logic        bit_stb,
  output line_state_t line_state
);

  localparam int            PW           = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] SAMPLE_PHASE = PW'(OVERSAMPLE / 2);

  line_state_t   line_now;
  line_state_t   line_q;
  logic [PW-1:0] phase_q;

  assign line_now = line_of(dp_i, dm_i);

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q  <= J;
      phase_q <= '0;
    end else begin
      line_q <= line_now;
      if (!rx_en)                 phase_q <= '0;
      else if (line_now != line_q) phase_q <= PW'(1);
      else                         phase_q <= phase_q + PW'(1);
    end
  end

  assign bit_stb    = rx_en && (phase_q == SAMPLE_PHASE);
  assign line_state = line_q;

endmodule

// File: rtl/usbdev_rx_decoder.sv
// USB full-speed receive front end: NRZI decode, SYNC detection, bit
// unstuffing, byte assembly and EOP detection on top of usbdev_rx_dpll.
//   clk, rst   : 48 MHz core clock, synchronous active-high reset
//   rx_en      : low forces IDLE and suppresses all strobes
//   dp_i, dm_i : synchronised D+/D- samples at 4x bit rate
//   data_o     : received byte (LSB first on the wire), qualified by valid_o
//   valid_o    : one-cycle byte strobe
//   sop_o      : one-cycle strobe when SYNC is matched
//   eop_o      : one-cycle strobe when a packet ends or is aborted
//   err_o      : one-cycle strobe on stuff error, SE1 or partial byte at EOP
//   active_o   : high from the sop_o cycle through the eop_o cycle
module usbdev_rx_decoder
  import usbdev_pkg::*;
#(
  parameter int OVERSAMPLE     = 4,
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       dp_i,
  input  logic       dm_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       sop_o,
  output logic       eop_o,
  output logic       err_o,
  output logic       active_o
);

  localparam logic [2:0] STUFF_LIM = 3'(USB_STUFF_LIMIT);
  localparam logic [2:0] SYNC_MIN  = 3'(SYNC_MIN_ZEROS);

  logic        bit_stb;
  line_state_t line_state;

  usbdev_rx_dpll #(.OVERSAMPLE(OVERSAMPLE)) u_dpll (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .dp_i       (dp_i),
    .dm_i       (dm_i),
    .bit_stb    (bit_stb),
    .line_state (line_state)
  );

  rx_state_t   state_q, state_d;
  line_state_t prev_q, prev_d;
  logic [2:0]  zero_q, zero_d;     // SYNC zero count, saturating
  logic [2:0]  ones_q, ones_d;     // consecutive decoded 1s
  logic [2:0]  bcnt_q, bcnt_d;     // bits in the current byte
  logic [2:0]  jcnt_q, jcnt_d;     // consecutive J samples in ABORT
  logic        se0_q, se0_d;       // ABORT has seen SE0 since last K/SE1
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_d;
  logic        valid_d, sop_d, eop_d, err_d, active_d;

  logic       nrzi_bit;
  logic       is_jk;
  logic [7:0] shifted;

  assign nrzi_bit = (line_state == prev_q);
  assign is_jk    = (line_state == J) || (line_state == K);
  assign shifted  = {nrzi_bit, shreg_q[7:1]};

  // NOTE: every variable gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    prev_d  = bit_stb ? line_state : prev_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    bcnt_d  = bcnt_q;
    jcnt_d  = jcnt_q;
    se0_d   = se0_q;
    shreg_d = shreg_q;
    data_d  = data_o;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;

    if (bit_stb) begin
      unique case (state_q)
        IDLE: begin
          if (line_state == K) begin
            state_d = SYNC;
            zero_d  = '0;
          end
        end

        SYNC: begin
          if (!is_jk) begin
            state_d = IDLE;
          end else if (!nrzi_bit) begin
            zero_d = (zero_q == 3'd7) ? 3'd7 : zero_q + 3'd1;
          end else if (zero_q >= SYNC_MIN) begin
            state_d = DATA;
            sop_d   = 1'b1;
            ones_d  = 3'd1;   // the SYNC-terminating 1 counts toward stuffing
            bcnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end

        DATA: begin
          if (line_state == SE0) begin
            state_d = EOP;
          end else if (line_state == SE1) begin
            state_d = ABORT;
            err_d   = 1'b1;
            eop_d   = 1'b1;
            jcnt_d  = '0;
            se0_d   = 1'b0;
          end else if (ones_q == STUFF_LIM) begin
            if (nrzi_bit) begin
              state_d = ABORT;
              err_d   = 1'b1;
              eop_d   = 1'b1;
              jcnt_d  = '0;
              se0_d   = 1'b0;
            end else begin
              ones_d = '0;    // stuff bit: dropped, bit count untouched
            end
          end else begin
            ones_d  = nrzi_bit ? ones_q + 3'd1 : 3'd0;
            shreg_d = shifted;
            if (bcnt_q == 3'd7) begin
              data_d  = shifted;
              valid_d = 1'b1;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end
        end

        EOP: begin
          if (line_state == J) begin
            state_d = IDLE;
            eop_d   = 1'b1;
            err_d   = (bcnt_q != 3'd0);
          end else if (line_state != SE0) begin
            // Entry to ABORT already carries eop_o, so ABORT adds none.
            state_d = ABORT;
            eop_d   = 1'b1;
            err_d   = 1'b1;
            jcnt_d  = '0;
            se0_d   = 1'b0;
          end
        end

        ABORT: begin
          if (line_state == J) begin
            if (se0_q || (jcnt_q == 3'd7)) state_d = IDLE;
            else                           jcnt_d  = jcnt_q + 3'd1;
          end else if (line_state == SE0) begin
            se0_d  = 1'b1;
            jcnt_d = '0;
          end else begin
            se0_d  = 1'b0;
            jcnt_d = '0;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    active_d = sop_d || (active_o && !eop_o);
  end

  always_ff @(posedge clk) begin
    if (rst || !rx_en) begin
      state_q  <= IDLE;
      prev_q   <= J;
      zero_q   <= '0;
      ones_q   <= '0;
      bcnt_q   <= '0;
      jcnt_q   <= '0;
      se0_q    <= 1'b0;
      shreg_q  <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
      sop_o    <= 1'b0;
      eop_o    <= 1'b0;
      err_o    <= 1'b0;
      active_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      zero_q   <= zero_d;
      ones_q   <= ones_d;
      bcnt_q   <= bcnt_d;
      jcnt_q   <= jcnt_d;
      se0_q    <= se0_d;
      shreg_q  <= shreg_d;
      data_o   <= data_d;
      valid_o  <= valid_d;
      sop_o    <= sop_d;
      eop_o    <= eop_d;
      err_o    <= err_d;
      active_o <= active_d;
    end
  end

endmodule

// File: tb/tb_usbdev_rx_decoder.sv
// Self-checking bench for usbdev_rx_decoder. Packets are built from byte /
// bit lists, bit-stuffed and NRZI-encoded onto the pads; the expected strobe
// sequence is derived from the same bit list by the packet rules alone.
module tb_usbdev_rx_decoder;
  import usbdev_pkg::*;

  localparam int EV_SOP    = 'h100;
  localparam int EV_EOP    = 'h200;
  localparam int EV_EOPERR = 'h300;
  localparam int EV_ERR    = 'h400;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       dp_i, dm_i;
  logic [7:0] data_o;
  logic       valid_o, sop_o, eop_o, err_o, active_o;

  int errors = 0;
  int checks = 0;
  int got_q[$];

  usbdev_rx_decoder #(.OVERSAMPLE(4), .SYNC_MIN_ZEROS(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_en    (rx_en),
    .dp_i     (dp_i),
    .dm_i     (dm_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .sop_o    (sop_o),
    .eop_o    (eop_o),
    .err_o    (err_o),
    .active_o (active_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: records every strobe cycle as an event token.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (sop_o) begin
        got_q.push_back(EV_SOP);
        check("sop_not_with_valid", 32'(valid_o), 32'd0);
        check("active_at_sop", 32'(active_o), 32'd1);
      end
      if (valid_o) got_q.push_back(int'(data_o));
      if (eop_o) begin
        got_q.push_back(err_o ? EV_EOPERR : EV_EOP);
        check("active_at_eop", 32'(active_o), 32'd1);
      end else if (err_o) begin
        got_q.push_back(EV_ERR);
      end
    end
  end

  function automatic line_state_t flip(input line_state_t s);
    return (s == J) ? K : J;
  endfunction

  task automatic put(input line_state_t s, input int len);
    case (s)
      J:       {dp_i, dm_i} = 2'b10;
      K:       {dp_i, dm_i} = 2'b01;
      SE0:     {dp_i, dm_i} = 2'b00;
      default: {dp_i, dm_i} = 2'b11;
    endcase
    repeat (len) @(negedge clk);
  endtask

  task automatic push_bytes(inout bit bits[$], input logic [7:0] b);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
  endtask

  // Transmitter: idle, SYNC with the given zero count, stuffed NRZI data,
  // then SE0 SE0 J. jit alternates symbol lengths 5/3 clocks.
  task automatic send_packet(input bit bits[$], input int sync_zeros,
                             input bit stuff_en, input bit jit, input bit no_eop);
    line_state_t syms[$];
    line_state_t cur;
    int run;
    repeat (6) syms.push_back(J);
    cur = K;
    syms.push_back(cur);
    repeat (sync_zeros) begin
      cur = flip(cur);
      syms.push_back(cur);
    end
    syms.push_back(cur);
    run = 1;
    foreach (bits[i]) begin
      if (stuff_en && run == USB_STUFF_LIMIT) begin
        cur = flip(cur);
        syms.push_back(cur);
        run = 0;
      end
      if (!bits[i]) cur = flip(cur);
      syms.push_back(cur);
      run = bits[i] ? run + 1 : 0;
    end
    if (!no_eop) begin
      if (stuff_en && run == USB_STUFF_LIMIT) syms.push_back(flip(cur));
      syms.push_back(SE0);
      syms.push_back(SE0);
      repeat (7) syms.push_back(J);
    end
    foreach (syms[i]) put(syms[i], jit ? ((i % 2) ? 3 : 5) : 4);
  endtask

  // Reference: expected strobe tokens for a data bit list, from the packet
  // rules (six 1s force a stuff bit, a seventh 1 aborts, LSB-first bytes,
  // leftover bits at EOP are an error).
  function automatic void model(input bit bits[$], input int sync_zeros,
                                input bit stuff_en, output int ev[$]);
    int run, cnt, acc;
    ev = {};
    if (sync_zeros < 5) return;
    ev.push_back(EV_SOP);
    run = 1; cnt = 0; acc = 0;
    foreach (bits[i]) begin
      if (run == USB_STUFF_LIMIT) begin
        if (stuff_en) run = 0;
        else if (bits[i]) begin
          ev.push_back(EV_EOPERR);
          return;
        end else begin
          run = 0;
          continue;
        end
      end
      run = bits[i] ? run + 1 : 0;
      acc = acc | (int'(bits[i]) << cnt);
      cnt++;
      if (cnt == 8) begin
        ev.push_back(acc);
        acc = 0;
        cnt = 0;
      end
    end
    ev.push_back((cnt != 0) ? EV_EOPERR : EV_EOP);
  endfunction

  task automatic compare(input string name, input int exp[$]);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check($sformatf("%s_ev%0d", name, i), 32'(got_q[i]), 32'(exp[i]));
    got_q.delete();
  endtask

  task automatic run_case(input string name, input bit bits[$], input int sync_zeros,
                          input bit stuff_en, input bit jit);
    int ev[$];
    model(bits, sync_zeros, stuff_en, ev);
    send_packet(bits, sync_zeros, stuff_en, jit, 1'b0);
    compare(name, ev);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_data"},   32'(data_o),   32'd0);
    check({name, "_valid"},  32'(valid_o),  32'd0);
    check({name, "_sop"},    32'(sop_o),    32'd0);
    check({name, "_eop"},    32'(eop_o),    32'd0);
    check({name, "_err"},    32'(err_o),    32'd0);
    check({name, "_active"}, 32'(active_o), 32'd0);
  endtask

  initial begin
    bit bits[$];
    int ev[$];

    rst = 1'b1; rx_en = 1'b1; dp_i = 1'b1; dm_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    put(J, 40);

    bits = {}; push_bytes(bits, 8'hC3); push_bytes(bits, 8'h5A);
    run_case("c3_5a", bits, 6, 1'b1, 1'b0);

    bits = {}; push_bytes(bits, 8'hFF); push_bytes(bits, 8'h01);
    run_case("ff_01_stuff", bits, 6, 1'b1, 1'b0);

    bits = {}; push_bytes(bits, 8'h00);
    repeat (7) bits.push_back(1'b1);
    repeat (10) bits.push_back(1'($urandom));
    run_case("seven_ones", bits, 6, 1'b0, 1'b0);

    bits = {}; push_bytes(bits, 8'h3C);
    bits.push_back(1'b1); bits.push_back(1'b0); bits.push_back(1'b1); bits.push_back(1'b0);
    run_case("partial_12", bits, 6, 1'b1, 1'b0);

    bits = {}; push_bytes(bits, 8'hA5);
    run_case("jitter_a5", bits, 6, 1'b1, 1'b1);

    bits = {1'b1, 1'b1, 1'b1};
    run_case("sync_4_zeros", bits, 4, 1'b0, 1'b0);
    bits = {}; push_bytes(bits, 8'h96);
    run_case("sync_5_zeros", bits, 5, 1'b1, 1'b0);
    bits = {}; push_bytes(bits, 8'h69);
    run_case("sync_7_zeros", bits, 7, 1'b1, 1'b0);

    // Reset in the middle of a packet.
    bits = {1'b0, 1'b1, 1'b1, 1'b0};
    send_packet(bits, 6, 1'b1, 1'b0, 1'b1);
    check("rst_active_before", 32'(active_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    put(J, 60);
    ev = {EV_SOP};
    compare("rst_mid_events", ev);
    bits = {}; push_bytes(bits, 8'h7E);
    run_case("after_rst", bits, 6, 1'b1, 1'b0);

    // Receiver disabled in the middle of a packet.
    bits = {1'b1, 1'b0, 1'b0, 1'b1};
    send_packet(bits, 6, 1'b1, 1'b0, 1'b1);
    check("rxen_active_before", 32'(active_o), 32'd1);
    rx_en = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rxen_low");
    @(negedge clk);
    put(J, 20);
    rx_en = 1'b1;
    put(J, 40);
    ev = {EV_SOP};
    compare("rxen_events", ev);
    bits = {}; push_bytes(bits, 8'hE7); push_bytes(bits, 8'h18);
    run_case("after_rxen", bits, 6, 1'b1, 1'b0);

    // Randomised packets: stuffing-heavy bytes, optional ragged tail, jitter.
    for (int p = 0; p < 30; p++) begin
      int nbytes;
      int extra;
      nbytes = int'($urandom_range(1, 4));
      bits = {};
      for (int b = 0; b < nbytes; b++)
        push_bytes(bits, ($urandom_range(0, 9) < 3) ? 8'hFF : 8'($urandom));
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int e = 0; e < extra; e++) bits.push_back(1'($urandom));
      run_case($sformatf("rand%0d", p), bits, 6, 1'b1, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
